// File: rtl/dtw_axis_sample_fifo_if.sv
// AXI4-Stream beat channel into the DTW sample FIFO; the master drives data,
// the slave returns TREADY.
interface dtw_axis_sample_fifo_if #(
  parameter int TDATA_WIDTH = 32
);
  logic                     S_AXIS_TVALID;
  logic                     S_AXIS_TREADY;
  logic [TDATA_WIDTH-1:0]   S_AXIS_TDATA;
  logic [TDATA_WIDTH/8-1:0] S_AXIS_TSTRB;
  logic                     S_AXIS_TLAST;

  modport master (
    output S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TLAST,
    input  S_AXIS_TREADY
  );

  modport slave (
    input  S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TLAST,
    output S_AXIS_TREADY
  );
endinterface

// File: rtl/dtw_axis_sample_fifo.sv
// Unpacks strobed AXIS beats into samples (lowest lane first) feeding a FWFT FIFO with packet-end tags.
// One sample per cycle; TREADY only while idle or on the final lane of the held beat, and held low while full.
module dtw_axis_sample_fifo #(
  parameter int  C_S_AXIS_TDATA_WIDTH = 32,
  parameter int  SAMPLE_WIDTH         = 8,
  parameter int  FIFO_DEPTH           = 64,
  localparam int LANES                = C_S_AXIS_TDATA_WIDTH / SAMPLE_WIDTH,
  localparam int CW                   = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    S_AXIS_ACLK,
  input  logic                    S_AXIS_ARESETN,
  dtw_axis_sample_fifo_if.slave   s_axis,
  input  logic                    dtw_fifo_rden,
  input  logic                    dtw_fifo_flush,
  output logic [SAMPLE_WIDTH-1:0] dtw_fifo_dout,
  output logic                    dtw_fifo_last,
  output logic                    dtw_fifo_empty,
  output logic                    dtw_fifo_full,
  output logic [CW-1:0]           dtw_fifo_count,
  output logic [CW-1:0]           dtw_pkt_count,
  output logic                    err_null_beat
);

  localparam int SB = SAMPLE_WIDTH / 8;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, UNPACK} state_t;

  state_t                            state;
  logic [C_S_AXIS_TDATA_WIDTH-1:0]   data_q;
  logic [LANES-1:0]                  mask_q;
  logic                              last_q;

  logic [LANES-1:0]                  in_mask;
  logic [LANES-1:0]                  mask_rest;
  logic [SAMPLE_WIDTH-1:0]           wr_dat;
  logic                              found;
  logic                              lane_last;
  logic                              wr_en;
  logic                              rd_en;
  logic                              fin;
  logic                              tready;
  logic                              accept;

  logic [SAMPLE_WIDTH-1:0]           mem_dat [FIFO_DEPTH];
  logic                              mem_last[FIFO_DEPTH];
  logic [AW-1:0]                     wr_ptr;
  logic [AW-1:0]                     rd_ptr;
  logic [CW-1:0]                     count_q;
  logic [CW-1:0]                     count_nxt;
  logic [CW-1:0]                     pkt_q;
  logic                              full_q;
  logic                              empty_q;
  logic                              wr_last;
  logic                              rd_last;

  // A lane counts only when every byte strobe inside it is set.
  always_comb begin
    in_mask = '0;
    for (int l = 0; l < LANES; l++)
      in_mask[l] = &s_axis.S_AXIS_TSTRB[l*SB +: SB];
  end

  always_comb begin
    wr_dat = '0;
    found  = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if (!found && mask_q[l]) begin
        wr_dat = data_q[l*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        found  = 1'b1;
      end
    end
  end

  assign mask_rest = mask_q & (mask_q - 1'b1);
  assign lane_last = (mask_rest == '0);
  assign wr_en     = (state == UNPACK) && !full_q && !dtw_fifo_flush;
  assign fin       = wr_en && lane_last;
  assign rd_en     = dtw_fifo_rden && !empty_q && !dtw_fifo_flush;
  assign wr_last   = wr_en && last_q && lane_last;
  assign rd_last   = rd_en && mem_last[rd_ptr];

  // Ready on the final-lane cycle lets the next beat land without a bubble.
  assign tready = S_AXIS_ARESETN && !dtw_fifo_flush &&
                  ((state == IDLE) || ((state == UNPACK) && !full_q && lane_last));
  assign accept = s_axis.S_AXIS_TVALID && tready;
  assign s_axis.S_AXIS_TREADY = tready;

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state         <= IDLE;
      data_q        <= '0;
      mask_q        <= '0;
      last_q        <= 1'b0;
      err_null_beat <= 1'b0;
    end else if (dtw_fifo_flush) begin
      state         <= IDLE;
      mask_q        <= '0;
      err_null_beat <= 1'b0;
    end else begin
      if (wr_en)
        mask_q <= mask_rest;
      if (accept) begin
        if (in_mask != '0) begin
          data_q <= s_axis.S_AXIS_TDATA;
          mask_q <= in_mask;
          last_q <= s_axis.S_AXIS_TLAST;
          state  <= UNPACK;
        end else begin
          err_null_beat <= 1'b1;
          state         <= IDLE;
        end
      end else if (fin) begin
        state <= IDLE;
      end
    end
  end

  always_comb begin
    count_nxt = count_q;
    if (wr_en && !rd_en)
      count_nxt = count_q + 1'b1;
    else if (rd_en && !wr_en)
      count_nxt = count_q - 1'b1;
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (wr_en) begin
      mem_dat[wr_ptr]  <= wr_dat;
      mem_last[wr_ptr] <= last_q && lane_last;
    end
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      pkt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else if (dtw_fifo_flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      pkt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_nxt;
      full_q  <= (count_nxt == CW'(FIFO_DEPTH));
      empty_q <= (count_nxt == '0);
      if (wr_last && !rd_last)
        pkt_q <= pkt_q + 1'b1;
      else if (rd_last && !wr_last)
        pkt_q <= pkt_q - 1'b1;
    end
  end

  assign dtw_fifo_dout  = empty_q ? '0 : mem_dat[rd_ptr];
  assign dtw_fifo_last  = !empty_q && mem_last[rd_ptr];
  assign dtw_fifo_empty = empty_q;
  assign dtw_fifo_full  = full_q;
  assign dtw_fifo_count = count_q;
  assign dtw_pkt_count  = pkt_q;

endmodule

// File: tb/tb_dtw_axis_sample_fifo.sv
// Bench for dtw_axis_sample_fifo: vector table of single beats plus fill, throughput,
// flush and async-reset sequences; samples are checked against a scoreboard queue.
module tb_dtw_axis_sample_fifo;

  localparam int DW    = 32;
  localparam int SW    = 8;
  localparam int DEPTH = 64;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rden = 1'b0;
  logic          flush = 1'b0;
  logic [SW-1:0] dout;
  logic          last;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic [CW-1:0] pkt;
  logic          err;

  always #5 clk = ~clk;

  dtw_axis_sample_fifo_if #(.TDATA_WIDTH(DW)) s_axis ();

  dtw_axis_sample_fifo #(
    .C_S_AXIS_TDATA_WIDTH(DW),
    .SAMPLE_WIDTH        (SW),
    .FIFO_DEPTH          (DEPTH)
  ) dut (
    .S_AXIS_ACLK    (clk),
    .S_AXIS_ARESETN (rst_n),
    .s_axis         (s_axis),
    .dtw_fifo_rden  (rden),
    .dtw_fifo_flush (flush),
    .dtw_fifo_dout  (dout),
    .dtw_fifo_last  (last),
    .dtw_fifo_empty (empty),
    .dtw_fifo_full  (full),
    .dtw_fifo_count (count),
    .dtw_pkt_count  (pkt),
    .err_null_beat  (err)
  );

  typedef struct packed {
    logic [SW-1:0] d;
    logic          l;
  } smp_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        tlast;
    int          exp_cnt;
    int          exp_pkt;
    logic        exp_err;
  } vec_t;

  smp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   max_count = 0;
  bit   track = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic l, output int acc);
    int n;
    int top;
    s_axis.S_AXIS_TVALID = 1'b1;
    s_axis.S_AXIS_TDATA  = d;
    s_axis.S_AXIS_TSTRB  = s;
    s_axis.S_AXIS_TLAST  = l;
    n = 0;
    @(negedge clk);
    while (!s_axis.S_AXIS_TREADY && n < 300) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    if (!s_axis.S_AXIS_TREADY) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: TREADY stayed 0, required 1 within 300 cycles");
    end else begin
      top = -1;
      for (int k = 0; k < 4; k++) if (s[k]) top = k;
      for (int k = 0; k < 4; k++)
        if (s[k]) sb.push_back('{d: d[k*8 +: 8], l: (l && k == top)});
    end
    @(posedge clk);
    #1;
    s_axis.S_AXIS_TVALID = 1'b0;
  endtask

  task automatic drain();
    int n;
    rden = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    step(1);
    rden = 1'b0;
    chk("drain_sb_left", sb.size(), 0);
    chk("drain_empty", empty, 1);
  endtask

  vec_t vecs[6];
  int   acc;
  int   accs[8];

  initial begin
    s_axis.S_AXIS_TVALID = 1'b0;
    s_axis.S_AXIS_TDATA  = '0;
    s_axis.S_AXIS_TSTRB  = '0;
    s_axis.S_AXIS_TLAST  = 1'b0;

    vecs[0] = '{32'h04030201, 4'hF, 1'b1, 4, 1, 1'b0};
    vecs[1] = '{32'hDDCCBBAA, 4'h5, 1'b0, 2, 0, 1'b0};
    vecs[2] = '{32'h12345678, 4'h0, 1'b1, 0, 0, 1'b1};
    vecs[3] = '{32'h11223344, 4'hA, 1'b1, 2, 1, 1'b0};
    vecs[4] = '{32'h55667788, 4'h6, 1'b1, 2, 1, 1'b0};
    vecs[5] = '{32'hA0B0C0D0, 4'h8, 1'b1, 1, 1, 1'b0};

    // Passive sample checker: each accepted read is compared with the scoreboard head.
    fork
      forever begin
        @(negedge clk);
        if (track && int'(count) > max_count) max_count = int'(count);
        if (rst_n && rden && !flush && !empty) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_sample: actual %0h required none (scoreboard empty)", dout);
          end else begin
            smp_t e;
            e = sb.pop_front();
            chk("sample_dat", dout, e.d);
            chk("sample_last", last, e.l);
          end
        end
      end
    join_none

    #12;
    chk("rst_tready", s_axis.S_AXIS_TREADY, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_pkt", pkt, 0);
    chk("rst_last", last, 0);
    chk("rst_dout", dout, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("tready_after_reset", s_axis.S_AXIS_TREADY, 1);
    step(1);

    for (int i = 0; i < 6; i++) begin
      send_beat(vecs[i].data, vecs[i].strb, vecs[i].tlast, acc);
      step(6);
      chk($sformatf("vec%0d_count", i), count, vecs[i].exp_cnt);
      chk($sformatf("vec%0d_pkt", i), pkt, vecs[i].exp_pkt);
      chk($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
      drain();
      chk($sformatf("vec%0d_pkt_drained", i), pkt, 0);
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      chk($sformatf("vec%0d_err_after_flush", i), err, 0);
    end

    rden = 1'b1;
    step(3);
    chk("empty_read_count", count, 0);
    chk("empty_read_empty", empty, 1);
    rden = 1'b0;

    // Fill without reads: beat 17 is taken but held with TREADY low.
    for (int i = 0; i < 17; i++) begin
      logic [31:0] d;
      d = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      send_beat(d, 4'hF, (i == 16), acc);
    end
    step(5);
    chk("fill_full", full, 1);
    chk("fill_count", count, DEPTH);
    chk("fill_tready", s_axis.S_AXIS_TREADY, 0);
    chk("fill_pkt", pkt, 0);
    step(3);
    chk("fill_tready_held", s_axis.S_AXIS_TREADY, 0);
    drain();
    chk("fill_pkt_drained", pkt, 0);

    // Continuous reads with back-to-back beats.
    rden = 1'b1;
    max_count = 0;
    track = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] d;
      d = {8'(8'h80 + 4*i+3), 8'(8'h80 + 4*i+2), 8'(8'h80 + 4*i+1), 8'(8'h80 + 4*i)};
      send_beat(d, 4'hF, (i == 7), accs[i]);
    end
    for (int i = 1; i < 8; i++)
      chk($sformatf("tready_period_%0d", i), accs[i] - accs[i-1], 4);
    drain();
    track = 1'b0;
    chk("stream_max_count_le2", (max_count <= 2), 1);

    // Flush with lane 2 of the held beat still pending.
    send_beat(32'h44332211, 4'hF, 1'b1, acc);
    step(2);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_count_before", count, 2);
    chk("flush_tready", s_axis.S_AXIS_TREADY, 0);
    step(1);
    flush = 1'b0;
    sb.delete();
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_pkt", pkt, 0);
    send_beat(32'h88776655, 4'hF, 1'b0, acc);
    step(6);
    chk("post_flush_count", count, 4);
    drain();

    // Asynchronous reset with lane 2 pending.
    send_beat(32'h44332211, 4'hF, 1'b1, acc);
    step(2);
    rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_tready", s_axis.S_AXIS_TREADY, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    step(1);
    chk("arst_tready_after", s_axis.S_AXIS_TREADY, 1);
    send_beat(32'hCCBBAA99, 4'hF, 1'b1, acc);
    step(6);
    chk("post_arst_count", count, 4);
    chk("post_arst_pkt", pkt, 1);
    drain();
    chk("post_arst_pkt_drained", pkt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
